// File: rtl/quadrature_encoder_reader.sv
// rtl/quadrature_encoder_reader.sv - Avalon-MM 4x quadrature encoder reader with position and speed feedback
module quadrature_encoder_reader #(
    parameter int          FILTER_LEN = 4,
    parameter logic [31:0] ID_VALUE   = 32'hEA680004
) (
    input  logic        csi_MCLK_clk,
    input  logic        rsi_MRST_reset,
    input  logic [31:0] avs_ctrl_writedata,
    output logic [31:0] avs_ctrl_readdata,
    input  logic [3:0]  avs_ctrl_byteenable,
    input  logic [2:0]  avs_ctrl_address,
    input  logic        avs_ctrl_write,
    input  logic        avs_ctrl_read,
    output logic        avs_ctrl_waitrequest,
    input  logic        enc_a,
    input  logic        enc_b,
    input  logic        enc_z
);

    localparam logic [7:0] FILT_LAST = 8'(FILTER_LEN - 1);

    localparam logic [2:0] ADDR_ID     = 3'd0;
    localparam logic [2:0] ADDR_POS    = 3'd1;
    localparam logic [2:0] ADDR_CTRL   = 3'd2;
    localparam logic [2:0] ADDR_PERIOD = 3'd3;
    localparam logic [2:0] ADDR_SPEED  = 3'd4;
    localparam logic [2:0] ADDR_STATUS = 3'd5;

    // Input conditioning: index 0 = A, 1 = B, 2 = Z
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] filt;
    logic [7:0] fcnt [0:2];

    logic [1:0]  prev_ab;
    logic        prev_z;
    logic        step_up_r;
    logic        step_dn_r;
    logic        illegal_r;
    logic        z_rise_r;

    logic [31:0] position;
    logic [2:0]  ctrl;
    logic [31:0] period;
    logic [31:0] speed;
    logic [31:0] win_cnt;
    logic [31:0] accum;
    logic        err;
    logic        idx;
    logic        dir;

    logic        en;
    logic        inv;
    logic        zclr;
    logic [1:0]  cur_ab;
    logic [1:0]  gray_diff;
    logic [31:0] step_val;
    logic        wr_pos;
    logic        wr_ctrl;
    logic        wr_period;
    logic        wr_status;
    logic        clr_err;
    logic        clr_idx;

    function automatic logic [1:0] gray_to_idx(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return res;
    endfunction

    assign avs_ctrl_waitrequest = 1'b0;

    assign en   = ctrl[0];
    assign inv  = ctrl[1];
    assign zclr = ctrl[2];

    assign wr_pos    = avs_ctrl_write && (avs_ctrl_address == ADDR_POS);
    assign wr_ctrl   = avs_ctrl_write && (avs_ctrl_address == ADDR_CTRL);
    assign wr_period = avs_ctrl_write && (avs_ctrl_address == ADDR_PERIOD);
    assign wr_status = avs_ctrl_write && (avs_ctrl_address == ADDR_STATUS);
    assign clr_err   = wr_status && avs_ctrl_byteenable[0] && avs_ctrl_writedata[0];
    assign clr_idx   = wr_status && avs_ctrl_byteenable[0] && avs_ctrl_writedata[1];

    assign cur_ab    = {filt[0], filt[1]};
    assign gray_diff = gray_to_idx(cur_ab) - gray_to_idx(prev_ab);

    always_comb begin
        step_val = 32'd0;
        if (en && step_up_r)      step_val = 32'd1;
        else if (en && step_dn_r) step_val = 32'hFFFF_FFFF;
    end

    // Synchronizer and stability filter; a level is accepted on its FILTER_LEN-th equal sample
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            sync1 <= 3'b000;
            sync2 <= 3'b000;
            filt  <= 3'b000;
            for (int i = 0; i < 3; i++) fcnt[i] <= 8'd0;
        end else begin
            sync1 <= {enc_z, enc_b, enc_a};
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= 8'd0;
                end else if (fcnt[i] == FILT_LAST) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= 8'd0;
                end else begin
                    fcnt[i] <= fcnt[i] + 8'd1;
                end
            end
        end
    end

    // Decode stage; previous AB/Z are tracked regardless of EN
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            prev_ab   <= 2'b00;
            prev_z    <= 1'b0;
            step_up_r <= 1'b0;
            step_dn_r <= 1'b0;
            illegal_r <= 1'b0;
            z_rise_r  <= 1'b0;
        end else begin
            prev_ab   <= cur_ab;
            prev_z    <= filt[2];
            step_up_r <= inv ? (gray_diff == 2'd3) : (gray_diff == 2'd1);
            step_dn_r <= inv ? (gray_diff == 2'd1) : (gray_diff == 2'd3);
            illegal_r <= (gray_diff == 2'd2);
            z_rise_r  <= filt[2] && !prev_z;
        end
    end

    // Bus write wins over index clear, which wins over the decode step
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            position <= 32'd0;
        end else if (wr_pos) begin
            position <= merge_bytes(position, avs_ctrl_writedata, avs_ctrl_byteenable);
        end else if (en && zclr && z_rise_r) begin
            position <= 32'd0;
        end else begin
            position <= position + step_val;
        end
    end

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            ctrl <= 3'b000;
        end else if (wr_ctrl && avs_ctrl_byteenable[0]) begin
            ctrl <= avs_ctrl_writedata[2:0];
        end
    end

    // Sticky flags: a set event in the same cycle as a clear wins
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            err <= 1'b0;
            idx <= 1'b0;
            dir <= 1'b0;
        end else begin
            err <= illegal_r || (err && !clr_err);
            idx <= z_rise_r  || (idx && !clr_idx);
            if (en && step_up_r)      dir <= 1'b1;
            else if (en && step_dn_r) dir <= 1'b0;
        end
    end

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            period  <= 32'd0;
            speed   <= 32'd0;
            win_cnt <= 32'd0;
            accum   <= 32'd0;
        end else begin
            if (period == 32'd0) speed <= 32'd0;
            if (wr_period) begin
                period  <= merge_bytes(period, avs_ctrl_writedata, avs_ctrl_byteenable);
                win_cnt <= 32'd0;
                accum   <= 32'd0;
            end else if (period != 32'd0 && en) begin
                if (win_cnt == period - 32'd1) begin
                    speed   <= accum + step_val;
                    accum   <= 32'd0;
                    win_cnt <= 32'd0;
                end else begin
                    accum   <= accum + step_val;
                    win_cnt <= win_cnt + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            avs_ctrl_readdata <= 32'd0;
        end else if (avs_ctrl_read) begin
            case (avs_ctrl_address)
                ADDR_ID:     avs_ctrl_readdata <= ID_VALUE;
                ADDR_POS:    avs_ctrl_readdata <= position;
                ADDR_CTRL:   avs_ctrl_readdata <= {29'd0, ctrl};
                ADDR_PERIOD: avs_ctrl_readdata <= period;
                ADDR_SPEED:  avs_ctrl_readdata <= speed;
                ADDR_STATUS: avs_ctrl_readdata <= {29'd0, dir, idx, err};
                default:     avs_ctrl_readdata <= 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_quadrature_encoder_reader.sv
// tb/tb_quadrature_encoder_reader.sv - scoreboard bench for quadrature_encoder_reader
module tb_quadrature_encoder_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [3:0]  be = '0;
    logic [2:0]  addr = '0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic        waitreq;
    logic        enc_a = 1'b0;
    logic        enc_b = 1'b0;
    logic        enc_z = 1'b0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    logic rd_d = 1'b0;
    logic peek = 1'b0;
    logic run = 1'b0;
    logic fwd = 1'b1;
    int   mph = 0;

    quadrature_encoder_reader #(.FILTER_LEN(4), .ID_VALUE(32'hEA680004)) dut (
        .csi_MCLK_clk        (clk),
        .rsi_MRST_reset      (rst),
        .avs_ctrl_writedata  (wdata),
        .avs_ctrl_readdata   (rdata),
        .avs_ctrl_byteenable (be),
        .avs_ctrl_address    (addr),
        .avs_ctrl_write      (wr),
        .avs_ctrl_read       (rd),
        .avs_ctrl_waitrequest(waitreq),
        .enc_a               (enc_a),
        .enc_b               (enc_b),
        .enc_z               (enc_z)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_d <= rd;

    // Monitor: every presented read result is popped and compared
    always @(negedge clk) begin
        if (rd_d || peek) begin
            n_checks = n_checks + 2;
            if (q.size() == 0) begin
                $display("FAIL scoreboard_empty: got %h required nothing outstanding", rdata);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (rdata === e.exp) n_pass++;
                else $display("FAIL %s: got %h required %h", e.name, rdata, e.exp);
            end
            if (waitreq === 1'b0) n_pass++;
            else $display("FAIL waitrequest: got %b required 0", waitreq);
        end
    end

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] b);
        addr = a; wdata = d; be = b; wr = 1'b1;
        @(posedge clk); #1;
        wr = 1'b0; be = 4'h0;
    endtask

    task automatic bus_read(input logic [2:0] a, input logic [31:0] e, input string name);
        exp_t item;
        item.name = name;
        item.exp  = e;
        q.push_back(item);
        addr = a; rd = 1'b1;
        @(posedge clk); #1;
        rd = 1'b0;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_phase(input int ph);
        case (ph)
            0: begin enc_a = 1'b0; enc_b = 1'b0; end
            1: begin enc_a = 1'b0; enc_b = 1'b1; end
            2: begin enc_a = 1'b1; enc_b = 1'b1; end
            default: begin enc_a = 1'b1; enc_b = 1'b0; end
        endcase
    endtask

    task automatic forward_cycles(input int n);
        for (int i = 0; i < n * 4; i++) begin
            set_phase((i + 1) % 4);
            wait_clk(10);
        end
    endtask

    task automatic motion();
        while (run) begin
            repeat (20) @(posedge clk);
            #1;
            if (run) begin
                mph = fwd ? (mph + 1) % 4 : (mph + 3) % 4;
                set_phase(mph);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wait_clk(3);
        rst = 1'b0;
        wait_clk(2);

        bus_read(3'd0, 32'hEA680004, "id");
        bus_read(3'd1, 32'h0, "reset_position");
        bus_read(3'd4, 32'h0, "reset_speed");
        bus_read(3'd5, 32'h0, "reset_status");
        bus_read(3'd6, 32'h0, "addr6_zero");

        bus_write(3'd2, 32'h1, 4'hF);
        forward_cycles(8);
        wait_clk(10);
        bus_read(3'd1, 32'd32, "fwd_position");
        bus_read(3'd5, 32'h4, "fwd_status_dir");

        bus_write(3'd2, 32'h3, 4'hF);
        forward_cycles(8);
        wait_clk(10);
        bus_read(3'd1, 32'd0, "inv_position");
        bus_read(3'd5, 32'h0, "inv_status_dir");

        for (int g = 0; g < 3; g++) begin
            enc_a = 1'b1;
            wait_clk(3);
            enc_a = 1'b0;
            wait_clk(10);
        end
        bus_read(3'd1, 32'd0, "glitch_position");

        enc_a = 1'b1; enc_b = 1'b1;
        wait_clk(12);
        enc_a = 1'b0; enc_b = 1'b0;
        wait_clk(12);
        bus_read(3'd1, 32'd0, "jump_position");
        bus_read(3'd5, 32'h1, "jump_err");
        bus_write(3'd5, 32'h1, 4'hF);
        bus_read(3'd5, 32'h0, "err_cleared");

        bus_write(3'd2, 32'h1, 4'hF);
        bus_write(3'd1, 32'h7FFFFFFF, 4'hF);
        set_phase(1);
        wait_clk(12);
        bus_read(3'd1, 32'h80000000, "wrap_up");
        set_phase(0);
        wait_clk(12);
        bus_read(3'd1, 32'h7FFFFFFF, "wrap_down");

        bus_write(3'd2, 32'h5, 4'hF);
        enc_z = 1'b1;
        wait_clk(10);
        enc_z = 1'b0;
        wait_clk(10);
        bus_read(3'd1, 32'h0, "zclr_position");
        bus_read(3'd5, 32'h2, "zclr_idx");
        bus_write(3'd5, 32'h2, 4'hF);
        bus_read(3'd5, 32'h0, "idx_cleared");

        bus_write(3'd1, 32'h12345678, 4'hF);
        bus_write(3'd1, 32'h00000055, 4'h1);
        bus_read(3'd1, 32'h12345655, "byteenable_low");

        bus_write(3'd2, 32'h1, 4'hF);
        bus_write(3'd3, 32'd1000, 4'hF);
        mph = 0;
        fwd = 1'b1;
        run = 1'b1;
        fork
            motion();
        join_none
        wait_clk(2600);
        bus_read(3'd4, 32'd50, "speed_fwd");
        fwd = 1'b0;
        wait_clk(2600);
        bus_read(3'd4, 32'hFFFFFFCE, "speed_rev");

        wait_clk(7);
        #2;
        rst = 1'b1;
        begin
            exp_t item;
            item.name = "readdata_async_reset";
            item.exp  = 32'h0;
            q.push_back(item);
        end
        #1 peek = 1'b1;
        @(posedge clk); #1;
        peek = 1'b0;
        run = 1'b0;
        wait_clk(30);
        enc_a = 1'b0; enc_b = 1'b0; enc_z = 1'b0;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(3);
        bus_read(3'd1, 32'h0, "post_reset_position");
        bus_read(3'd2, 32'h0, "post_reset_ctrl");
        bus_read(3'd3, 32'h0, "post_reset_period");
        bus_read(3'd4, 32'h0, "post_reset_speed");
        bus_read(3'd5, 32'h0, "post_reset_status");

        wait_clk(3);
        if (q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: got %0d outstanding required 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
